bp_wormhole_stream_arbiter: RTL and testbench

Round-robin arbiter that shares one bsg_wormhole output link among `num_req_p` wormhole packet streams. It locks the grant from a packet's first (header) flit through its last flit, using the wormhole len field (num_flits-1) carried in that first flit. This prevents interleaving of packets. It sits in front of a wormhole link or a stream-to-burst converter.

---
 rtl/bp_wormhole_stream_arbiter.sv | 147 ++++++++++++++
 tb/tb_bp_wormhole_stream_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bp_wormhole_stream_arbiter.sv
// Round-robin arbiter sharing one wormhole link among several packet streams.
// The grant is locked from header to last flit using the header len field.
module bp_wormhole_stream_arbiter #(
  parameter int num_req_p     = 4,
  parameter int flit_width_p  = 64,
  parameter int cord_width_p  = 8,
  parameter int len_width_p   = 4,
  parameter int lg_num_req_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_req_p*flit_width_p-1:0] req_data_i,
  input  logic [num_req_p-1:0]              req_v_i,
  output logic [num_req_p-1:0]              req_ready_and_o,
  output logic [flit_width_p-1:0]           link_data_o,
  output logic                              link_v_o,
  input  logic                              link_ready_and_i,
  output logic [lg_num_req_lp-1:0]          grant_id_o,
  output logic                              grant_lock_o,
  output logic                              last_flit_o
);

  localparam logic [1:0] E_IDLE = 2'd0;
  localparam logic [1:0] E_HDR  = 2'd1;
  localparam logic [1:0] E_BODY = 2'd2;

  localparam logic [lg_num_req_lp-1:0] LAST_ID =
    lg_num_req_lp'(num_req_p - 1);

  logic [1:0]               state_q, state_d;
  logic [lg_num_req_lp-1:0] lock_id_q, lock_id_d;
  logic [lg_num_req_lp-1:0] ptr_q, ptr_d;
  logic [len_width_p-1:0]   cnt_q, cnt_d;

  logic [lg_num_req_lp-1:0] scan_id;
  logic [lg_num_req_lp-1:0] sel;
  logic [len_width_p-1:0]   len;
  logic                     accept;
  logic                     in_idle;
  logic                     found;
  int                       idx;

  // Pointer increment wraps at num_req_p, not at a power of two.
  function automatic logic [lg_num_req_lp-1:0] wrap_inc(
    input logic [lg_num_req_lp-1:0] x
  );
    if (x == LAST_ID) return '0;
    return x + 1'b1;
  endfunction

  // Round-robin scan starting at the priority pointer.
  always_comb begin
    scan_id = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < num_req_p; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!found && req_v_i[idx]) begin
        found   = 1'b1;
        scan_id = lg_num_req_lp'(idx);
      end
    end
  end

  // Output datapath and handshake, combinational from state and inputs.
  always_comb begin
    in_idle     = (state_q == E_IDLE);
    sel         = in_idle ? scan_id : lock_id_q;
    link_data_o = req_data_i[sel*flit_width_p +: flit_width_p];
    link_v_o    = in_idle ? (|req_v_i) : req_v_i[sel];
    accept      = link_v_o & link_ready_and_i;
    len         = link_data_o[cord_width_p +: len_width_p];
    grant_id_o  = sel;
    grant_lock_o = !in_idle;
    last_flit_o  = link_v_o &
      (((state_q == E_BODY) && (cnt_q == len_width_p'(1))) ||
       ((state_q != E_BODY) && (len == '0)));
    req_ready_and_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      req_ready_and_o[i] = accept & (sel == lg_num_req_lp'(i));
    end
  end

  // Next-state logic for the packet lock FSM.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    case (state_q)
      E_IDLE: begin
        if (|req_v_i) begin
          if (accept) begin
            if (len == '0) begin
              ptr_d = wrap_inc(sel);
            end else begin
              cnt_d     = len;
              lock_id_d = sel;
              state_d   = E_BODY;
            end
          end else begin
            lock_id_d = sel;
            state_d   = E_HDR;
          end
        end
      end
      E_HDR: begin
        if (accept) begin
          if (len == '0) begin
            ptr_d   = wrap_inc(lock_id_q);
            state_d = E_IDLE;
          end else begin
            cnt_d   = len;
            state_d = E_BODY;
          end
        end
      end
      E_BODY: begin
        if (accept) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == len_width_p'(1)) begin
            ptr_d   = wrap_inc(lock_id_q);
            state_d = E_IDLE;
          end
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= E_IDLE;
      lock_id_q <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bp_wormhole_stream_arbiter.sv
// Directed bench for the wormhole stream arbiter.
// Vectors are hand-derived; every check goes through chk.
module tb_bp_wormhole_stream_arbiter;

  logic         clk;
  logic         rst_n;
  logic [63:0]  d [4];
  logic [3:0]   v;
  logic [255:0] req_data;
  logic [3:0]   ready_o;
  logic [63:0]  link_data;
  logic         link_v;
  logic         rdy;
  logic [1:0]   grant_id;
  logic         grant_lock;
  logic         last_flit;

  int errors;
  int checks;

  bp_wormhole_stream_arbiter #(
    .num_req_p(4),
    .flit_width_p(64),
    .cord_width_p(8),
    .len_width_p(4)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .req_data_i(req_data),
    .req_v_i(v),
    .req_ready_and_o(ready_o),
    .link_data_o(link_data),
    .link_v_o(link_v),
    .link_ready_and_i(rdy),
    .grant_id_o(grant_id),
    .grant_lock_o(grant_lock),
    .last_flit_o(last_flit)
  );

  always_comb req_data = {d[3], d[2], d[1], d[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] mk(input logic [7:0] tag,
                                     input logic [3:0] len);
    return {44'h0, tag, len, 8'h11};
  endfunction

  task automatic chk(input string t, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", t, got, exp);
    end
  endtask

  task automatic outs(input string t, input logic ev, input logic [1:0] eg,
                      input logic el, input logic elast);
    chk({t, ".v"}, 64'(link_v), 64'(ev));
    chk({t, ".gnt"}, 64'(grant_id), 64'(eg));
    chk({t, ".lock"}, 64'(grant_lock), 64'(el));
    chk({t, ".last"}, 64'(last_flit), 64'(elast));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    v = '0;
    #2 rst_n = 1'b0;
    #2;
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    v      = '0;
    rdy    = 1'b0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    #1;
    outs("rst", 1'b0, 2'd0, 1'b0, 1'b0);
    chk("rst.rdy", 64'(ready_o), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // single requester, len=3
    rdy = 1'b1;
    v = 4'b0001; d[0] = mk(8'h10, 4'd3); #1;
    outs("s1", 1'b1, 2'd0, 1'b0, 1'b0);
    chk("s1.data", link_data, mk(8'h10, 4'd3));
    chk("s1.rdy", 64'(ready_o), 64'h1);
    tick();
    d[0] = mk(8'h11, 4'hF); #1;
    outs("s2", 1'b1, 2'd0, 1'b1, 1'b0);
    tick();
    d[0] = mk(8'h12, 4'hF); #1;
    outs("s3", 1'b1, 2'd0, 1'b1, 1'b0);
    tick();
    d[0] = mk(8'h13, 4'hF); #1;
    outs("s4", 1'b1, 2'd0, 1'b1, 1'b1);
    chk("s4.data", link_data, mk(8'h13, 4'hF));
    tick();
    v = 4'b0011; d[0] = mk(8'h20, 4'd0); d[1] = mk(8'h21, 4'd0); #1;
    outs("s.ptr1", 1'b1, 2'd1, 1'b0, 1'b1);
    tick();
    v = 4'b0001; #1;
    outs("s.ptr2", 1'b1, 2'd0, 1'b0, 1'b1);
    tick();
    do_reset();

    // contention, req 0 and 2 with len=1
    v = 4'b0101; d[0] = mk(8'h30, 4'd1); d[2] = mk(8'h32, 4'd1); #1;
    outs("c1", 1'b1, 2'd0, 1'b0, 1'b0);
    chk("c1.rdy", 64'(ready_o), 64'h1);
    tick();
    d[0] = mk(8'h31, 4'hF); #1;
    outs("c2", 1'b1, 2'd0, 1'b1, 1'b1);
    tick();
    v = 4'b0100; #1;
    outs("c3", 1'b1, 2'd2, 1'b0, 1'b0);
    chk("c3.data", link_data, mk(8'h32, 4'd1));
    tick();
    d[2] = mk(8'h33, 4'hF); #1;
    outs("c4", 1'b1, 2'd2, 1'b1, 1'b1);
    tick();
    v = 4'b1001; d[0] = mk(8'h34, 4'd0); d[3] = mk(8'h35, 4'd0); #1;
    outs("c.ptr3", 1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    do_reset();

    // header stall with ptr at 1
    v = 4'b0001; d[0] = mk(8'h40, 4'd0); #1;
    tick();
    rdy = 1'b0;
    v = 4'b0010; d[1] = mk(8'h41, 4'd1); #1;
    outs("h1", 1'b1, 2'd1, 1'b0, 1'b0);
    chk("h1.rdy", 64'(ready_o), 64'h0);
    tick();
    v = 4'b0011; d[0] = mk(8'h42, 4'd0); #1;
    outs("h2", 1'b1, 2'd1, 1'b1, 1'b0);
    chk("h2.data", link_data, mk(8'h41, 4'd1));
    chk("h2.rdy", 64'(ready_o), 64'h0);
    tick();
    #1;
    outs("h3", 1'b1, 2'd1, 1'b1, 1'b0);
    chk("h3.data", link_data, mk(8'h41, 4'd1));
    tick();
    rdy = 1'b1; #1;
    chk("h4.rdy", 64'(ready_o), 64'h2);
    chk("h4.gnt", 64'(grant_id), 64'd1);
    tick();
    d[1] = mk(8'h43, 4'hF); #1;
    outs("h5", 1'b1, 2'd1, 1'b1, 1'b1);
    tick();
    v = 4'b0001; #1;
    outs("h6", 1'b1, 2'd0, 1'b0, 1'b1);
    chk("h6.data", link_data, mk(8'h42, 4'd0));
    tick();
    do_reset();

    // single-flit round robin
    v = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = mk(8'(8'h50 + i), 4'd0);
    for (int k = 0; k < 6; k++) begin
      #1;
      outs($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 1'b0, 1'b1);
      chk($sformatf("rr%0d.rdy", k), 64'(ready_o), 64'(4'b1 << (k % 4)));
      tick();
    end
    do_reset();

    // body bubble on req 2 while req 3 waits
    v = 4'b0100; d[2] = mk(8'h60, 4'd3); #1;
    outs("b1", 1'b1, 2'd2, 1'b0, 1'b0);
    tick();
    d[2] = mk(8'h61, 4'hF); #1;
    outs("b2", 1'b1, 2'd2, 1'b1, 1'b0);
    tick();
    v = 4'b1000; d[3] = mk(8'h70, 4'd0); #1;
    outs("b3", 1'b0, 2'd2, 1'b1, 1'b0);
    chk("b3.rdy", 64'(ready_o), 64'h0);
    tick();
    #1;
    outs("b4", 1'b0, 2'd2, 1'b1, 1'b0);
    chk("b4.rdy", 64'(ready_o), 64'h0);
    tick();
    v = 4'b1100; d[2] = mk(8'h62, 4'hF); #1;
    outs("b5", 1'b1, 2'd2, 1'b1, 1'b0);
    chk("b5.data", link_data, mk(8'h62, 4'hF));
    tick();
    d[2] = mk(8'h63, 4'hF); #1;
    outs("b6", 1'b1, 2'd2, 1'b1, 1'b1);
    tick();
    v = 4'b1000; #1;
    outs("b7", 1'b1, 2'd3, 1'b0, 1'b1);
    tick();
    do_reset();

    // asynchronous reset in the middle of a body
    v = 4'b0010; d[1] = mk(8'h80, 4'd0); #1;
    tick();
    v = 4'b0001; d[0] = mk(8'h81, 4'd3); #1;
    chk("a1.gnt", 64'(grant_id), 64'd0);
    tick();
    d[0] = mk(8'h82, 4'hF); #1;
    chk("a2.lock", 64'(grant_lock), 64'd1);
    tick();
    #1;
    chk("a3.lock", 64'(grant_lock), 64'd1);
    rst_n = 1'b0; #1;
    chk("a4.lock", 64'(grant_lock), 64'd0);
    v = 4'b0000; #1;
    outs("a5", 1'b0, 2'd0, 1'b0, 1'b0);
    chk("a5.rdy", 64'(ready_o), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    v = 4'b1010; d[1] = mk(8'h90, 4'd0); d[3] = mk(8'h91, 4'd0); #1;
    outs("a6", 1'b1, 2'd1, 1'b0, 1'b1);
    tick();
    v = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
